// File: rtl/sap_pkg.sv
// sap_pkg: control-word layout shared by the SAP datapath and its control unit.
//   - CW_* constants give the bit position of each control line in the 16-bit word.
//   - ctrl_t is the same word as a packed struct, so fields can be referenced by name.
//   - multi_source() flags a bus-source vector with more than one bit set.
package sap_pkg;

  localparam int CW_WIDTH   = 16;

  localparam int CW_HALT    = 15;
  localparam int CW_MAR_IN  = 14;
  localparam int CW_RAM_IN  = 13;
  localparam int CW_RAM_OUT = 12;
  localparam int CW_IR_OUT  = 11;
  localparam int CW_IR_IN   = 10;
  localparam int CW_A_IN    = 9;
  localparam int CW_A_OUT   = 8;
  localparam int CW_ALU_OUT = 7;
  localparam int CW_ALU_SUB = 6;
  localparam int CW_B_IN    = 5;
  localparam int CW_OUT_IN  = 4;
  localparam int CW_PC_INC  = 3;
  localparam int CW_PC_OUT  = 2;
  localparam int CW_JUMP    = 1;
  localparam int CW_FLAGS   = 0;

  // Field order matches the bit positions above, MSB first.
  typedef struct packed {
    logic halt;
    logic mar_in;
    logic ram_in;
    logic ram_out;
    logic ir_out;
    logic ir_in;
    logic a_in;
    logic a_out;
    logic alu_out;
    logic alu_sub;
    logic b_in;
    logic out_in;
    logic pc_inc;
    logic pc_out;
    logic jump;
    logic flags_update;
  } ctrl_t;

  // True when more than one bit of the source-enable vector is set.
  function automatic logic multi_source(input logic [4:0] srcs);
    return (srcs & (srcs - 5'd1)) != 5'd0;
  endfunction

endpackage

// File: rtl/sap_ram.sv
// sap_ram: program/data RAM, 2^ADDR_WIDTH words of DATA_WIDTH bits.
//   clk        : write clock
//   prog_we/prog_addr/prog_data : loader write port (wins over datapath write)
//   dp_we/dp_addr/dp_data       : datapath write (RAM_IN)
//   rd_addr/rd_data             : asynchronous read port
// Contents are not reset, so a program survives a datapath reset.
module sap_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  prog_we,
  input  logic [ADDR_WIDTH-1:0] prog_addr,
  input  logic [DATA_WIDTH-1:0] prog_data,
  input  logic                  dp_we,
  input  logic [ADDR_WIDTH-1:0] dp_addr,
  input  logic [DATA_WIDTH-1:0] dp_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Single write port: the loader takes it whenever it strobes.
  always_ff @(posedge clk) begin
    if (prog_we) begin
      mem[prog_addr] <= prog_data;
    end else if (dp_we) begin
      mem[dp_addr] <= dp_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sap_datapath.sv
// sap_datapath: SAP register/bus datapath executing one control word per cycle.
//   i_CLOCK, i_RESET_n         : clock, asynchronous active-low reset
//   i_CONTROL_SIGNALS          : control word (layout in sap_pkg)
//   i_PROG_WE/ADDR/DATA        : program loader into RAM, active even when halted
//   o_IR_DATA                  : opcode, IR upper half
//   o_ZERO_FLAG, o_CARRY_FLAG  : registered ALU flags
//   o_OUT_DATA                 : OUT register
//   o_BUS                      : combinational bus value
//   o_HALTED, o_BUS_CONFLICT   : sticky status, cleared only by reset
module sap_datapath
  import sap_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 4,
  parameter int CONTROL_WIDTH = 16
) (
  input  logic                      i_CLOCK,
  input  logic                      i_RESET_n,
  input  logic [CONTROL_WIDTH-1:0]  i_CONTROL_SIGNALS,
  input  logic                      i_PROG_WE,
  input  logic [ADDR_WIDTH-1:0]     i_PROG_ADDR,
  input  logic [DATA_WIDTH-1:0]     i_PROG_DATA,
  output logic [DATA_WIDTH/2-1:0]   o_IR_DATA,
  output logic                      o_ZERO_FLAG,
  output logic                      o_CARRY_FLAG,
  output logic [DATA_WIDTH-1:0]     o_OUT_DATA,
  output logic [DATA_WIDTH-1:0]     o_BUS,
  output logic                      o_HALTED,
  output logic                      o_BUS_CONFLICT
);

  localparam int HALF = DATA_WIDTH / 2;

  ctrl_t ctrl;
  assign ctrl = ctrl_t'(i_CONTROL_SIGNALS[CW_WIDTH-1:0]);

  logic [DATA_WIDTH-1:0] a_reg;
  logic [DATA_WIDTH-1:0] b_reg;
  logic [DATA_WIDTH-1:0] ir_reg;
  logic [DATA_WIDTH-1:0] out_reg;
  logic [ADDR_WIDTH-1:0] mar_reg;
  logic [ADDR_WIDTH-1:0] pc_reg;
  logic                  zero_reg;
  logic                  carry_reg;
  logic                  halted_reg;
  logic                  conflict_reg;

  logic [DATA_WIDTH-1:0] ram_data;
  logic [DATA_WIDTH-1:0] bus;
  logic [DATA_WIDTH-1:0] b_operand;
  logic [DATA_WIDTH:0]   alu_sum;
  logic [DATA_WIDTH-1:0] alu_result;
  logic [4:0]            src_vec;
  logic                  update_en;

  // Once halted, control-word effects stop; the loader and bus are unaffected.
  assign update_en = ~halted_reg;

  // Subtract is A + ~B + 1, so carry out means "no borrow" (A >= B).
  assign b_operand  = ctrl.alu_sub ? ~b_reg : b_reg;
  assign alu_sum    = {1'b0, a_reg} + {1'b0, b_operand}
                    + {{DATA_WIDTH{1'b0}}, ctrl.alu_sub};
  assign alu_result = alu_sum[DATA_WIDTH-1:0];

  // Bus source priority: ALU > A > RAM > IR > PC; idle bus reads zero.
  always_comb begin
    bus = '0;
    if (ctrl.alu_out) begin
      bus = alu_result;
    end else if (ctrl.a_out) begin
      bus = a_reg;
    end else if (ctrl.ram_out) begin
      bus = ram_data;
    end else if (ctrl.ir_out) begin
      bus = {{(DATA_WIDTH-HALF){1'b0}}, ir_reg[HALF-1:0]};
    end else if (ctrl.pc_out) begin
      bus = {{(DATA_WIDTH-ADDR_WIDTH){1'b0}}, pc_reg};
    end
  end

  assign src_vec = {ctrl.alu_out, ctrl.a_out, ctrl.ram_out, ctrl.ir_out, ctrl.pc_out};

  always_ff @(posedge i_CLOCK or negedge i_RESET_n) begin
    if (!i_RESET_n) begin
      a_reg        <= '0;
      b_reg        <= '0;
      ir_reg       <= '0;
      out_reg      <= '0;
      mar_reg      <= '0;
      pc_reg       <= '0;
      zero_reg     <= 1'b0;
      carry_reg    <= 1'b0;
      halted_reg   <= 1'b0;
      conflict_reg <= 1'b0;
    end else begin
      if (update_en) begin
        if (ctrl.mar_in) mar_reg <= bus[ADDR_WIDTH-1:0];
        if (ctrl.ir_in)  ir_reg  <= bus;
        if (ctrl.a_in)   a_reg   <= bus;
        if (ctrl.b_in)   b_reg   <= bus;
        if (ctrl.out_in) out_reg <= bus;
        // JUMP overrides PC_INC.
        if (ctrl.jump) begin
          pc_reg <= bus[ADDR_WIDTH-1:0];
        end else if (ctrl.pc_inc) begin
          pc_reg <= pc_reg + ADDR_WIDTH'(1);
        end
        // Flags use the pre-edge ALU inputs, independent of a same-cycle A_IN.
        if (ctrl.flags_update) begin
          zero_reg  <= (alu_result == '0);
          carry_reg <= alu_sum[DATA_WIDTH];
        end
        if (ctrl.halt) halted_reg <= 1'b1;
      end
      if (multi_source(src_vec)) conflict_reg <= 1'b1;
    end
  end

  sap_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk       (i_CLOCK),
    .prog_we   (i_PROG_WE),
    .prog_addr (i_PROG_ADDR),
    .prog_data (i_PROG_DATA),
    .dp_we     (ctrl.ram_in & update_en),
    .dp_addr   (mar_reg),
    .dp_data   (bus),
    .rd_addr   (mar_reg),
    .rd_data   (ram_data)
  );

  assign o_IR_DATA      = ir_reg[DATA_WIDTH-1:HALF];
  assign o_ZERO_FLAG    = zero_reg;
  assign o_CARRY_FLAG   = carry_reg;
  assign o_OUT_DATA     = out_reg;
  assign o_BUS          = bus;
  assign o_HALTED       = halted_reg;
  assign o_BUS_CONFLICT = conflict_reg;

endmodule

// File: tb/tb_sap_datapath.sv
// tb_sap_datapath: directed scenarios plus randomized control words, checked
// against a behavioural model of the SAP datapath kept in the bench.
module tb_sap_datapath;

  localparam logic [15:0] HALT    = 16'h8000;
  localparam logic [15:0] MAR_IN  = 16'h4000;
  localparam logic [15:0] RAM_IN  = 16'h2000;
  localparam logic [15:0] RAM_OUT = 16'h1000;
  localparam logic [15:0] IR_OUT  = 16'h0800;
  localparam logic [15:0] IR_IN   = 16'h0400;
  localparam logic [15:0] A_IN    = 16'h0200;
  localparam logic [15:0] A_OUT   = 16'h0100;
  localparam logic [15:0] ALU_OUT = 16'h0080;
  localparam logic [15:0] ALU_SUB = 16'h0040;
  localparam logic [15:0] B_IN    = 16'h0020;
  localparam logic [15:0] OUT_IN  = 16'h0010;
  localparam logic [15:0] PC_INC  = 16'h0008;
  localparam logic [15:0] PC_OUT  = 16'h0004;
  localparam logic [15:0] JUMP    = 16'h0002;
  localparam logic [15:0] FLAGS   = 16'h0001;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] ctrl = '0;
  logic        prog_we = 1'b0;
  logic [3:0]  prog_addr = '0;
  logic [7:0]  prog_data = '0;
  logic [3:0]  ir_data;
  logic        zero_flag, carry_flag, halted, conflict;
  logic [7:0]  out_data, bus;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  int m_a, m_b, m_ir, m_out, m_mar, m_pc;
  int m_z, m_c, m_halt, m_conf;
  int m_ram [16];

  always #5 clk = ~clk;

  sap_datapath dut (
    .i_CLOCK           (clk),
    .i_RESET_n         (rst_n),
    .i_CONTROL_SIGNALS (ctrl),
    .i_PROG_WE         (prog_we),
    .i_PROG_ADDR       (prog_addr),
    .i_PROG_DATA       (prog_data),
    .o_IR_DATA         (ir_data),
    .o_ZERO_FLAG       (zero_flag),
    .o_CARRY_FLAG      (carry_flag),
    .o_OUT_DATA        (out_data),
    .o_BUS             (bus),
    .o_HALTED          (halted),
    .o_BUS_CONFLICT    (conflict)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int alu_result(input logic [15:0] c);
    if (c[6]) return (m_a - m_b + 256) % 256;
    return (m_a + m_b) % 256;
  endfunction

  function automatic int alu_carry(input logic [15:0] c);
    if (c[6]) return (m_a >= m_b) ? 1 : 0;
    return (m_a + m_b > 255) ? 1 : 0;
  endfunction

  function automatic int model_bus(input logic [15:0] c);
    if (c[7])  return alu_result(c);
    if (c[8])  return m_a;
    if (c[12]) return m_ram[m_mar];
    if (c[11]) return m_ir % 16;
    if (c[2])  return m_pc;
    return 0;
  endfunction

  task automatic model_reset();
    m_a = 0; m_b = 0; m_ir = 0; m_out = 0; m_mar = 0; m_pc = 0;
    m_z = 0; m_c = 0; m_halt = 0; m_conf = 0;
  endtask

  task automatic check_regs(input string tag);
    check({tag, "_ir"},   ir_data,    m_ir / 16);
    check({tag, "_z"},    zero_flag,  m_z);
    check({tag, "_c"},    carry_flag, m_c);
    check({tag, "_out"},  out_data,   m_out);
    check({tag, "_halt"}, halted,     m_halt);
    check({tag, "_conf"}, conflict,   m_conf);
  endtask

  // One clock cycle: drive word (and optional loader write), check bus, clock, check state.
  task automatic step(input logic [15:0] c, input bit we = 1'b0,
                      input int wa = 0, input int wd = 0);
    int b, nsrc, old_mar;
    ctrl = c; prog_we = we; prog_addr = 4'(wa); prog_data = 8'(wd);
    #1;
    b = model_bus(c);
    check("bus", bus, b);
    nsrc = int'(c[7]) + int'(c[8]) + int'(c[12]) + int'(c[11]) + int'(c[2]);
    old_mar = m_mar;
    @(posedge clk);
    if (we) m_ram[wa] = wd;
    else if (m_halt == 0 && c[13]) m_ram[old_mar] = b;
    if (m_halt == 0) begin
      if (c[0]) begin
        m_z = (alu_result(c) == 0) ? 1 : 0;
        m_c = alu_carry(c);
      end
      if (c[14]) m_mar = b % 16;
      if (c[10]) m_ir = b;
      if (c[9])  m_a = b;
      if (c[5])  m_b = b;
      if (c[4])  m_out = b;
      if (c[1])       m_pc = b % 16;
      else if (c[3])  m_pc = (m_pc + 1) % 16;
      if (c[15]) m_halt = 1;
    end
    if (nsrc > 1) m_conf = 1;
    #1;
    prog_we = 1'b0;
    check_regs("reg");
    $display("step ctrl=%04h we=%0d bus=%02h ir=%0h z=%0d c=%0d out=%02h halt=%0d conf=%0d",
             c, we, b, ir_data, zero_flag, carry_flag, out_data, halted, conflict);
  endtask

  // Combinational look at the bus for a given word, without clocking.
  task automatic peek(input logic [15:0] c, input string tag, input int exp);
    ctrl = c;
    #1;
    check(tag, bus, exp);
  endtask

  task automatic load_ab(input int a, input int b);
    step(16'h0, 1'b1, m_mar, a);
    step(RAM_OUT | A_IN);
    step(16'h0, 1'b1, m_mar, b);
    step(RAM_OUT | B_IN);
  endtask

  initial begin
    int a_keep;
    model_reset();
    for (int i = 0; i < 16; i++) m_ram[i] = 0;

    // Reset state
    #12;
    check_regs("rst");
    peek(16'h0, "rst_idle_bus", 0);
    rst_n = 1'b1;

    // Preload RAM with random data, then the LDA 5 program
    for (int i = 0; i < 16; i++) step(16'h0, 1'b1, i, int'($urandom_range(0, 255)));
    step(16'h0, 1'b1, 5, 8'h2A);
    step(16'h0, 1'b1, 0, 8'h15);
    step(PC_OUT | MAR_IN);
    step(RAM_OUT | IR_IN | PC_INC);
    step(IR_OUT | MAR_IN);
    step(RAM_OUT | A_IN);
    check("lda_opcode", ir_data, 1);
    peek(A_OUT, "lda_a", 8'h2A);
    peek(PC_OUT, "lda_pc", 1);
    peek(IR_OUT, "lda_ir_low", 5);

    // ADD with carry out
    load_ab(8'hF0, 8'h20);
    step(ALU_OUT | A_IN | FLAGS);
    peek(A_OUT, "add_a", 8'h10);
    check("add_carry", carry_flag, 1);
    check("add_zero", zero_flag, 0);

    // SUB equal, then SUB with borrow
    load_ab(8'h07, 8'h07);
    step(ALU_OUT | ALU_SUB | A_IN | FLAGS);
    peek(A_OUT, "sub_eq_a", 0);
    check("sub_eq_zero", zero_flag, 1);
    check("sub_eq_carry", carry_flag, 1);
    load_ab(8'h03, 8'h05);
    step(ALU_OUT | ALU_SUB | A_IN | FLAGS);
    peek(A_OUT, "sub_lt_a", 8'hFE);
    check("sub_lt_carry", carry_flag, 0);
    check("sub_lt_zero", zero_flag, 0);

    // OUT register from ALU, B unchanged
    step(ALU_OUT | OUT_IN);
    check("out_reg", out_data, 8'h03);

    // PC wrap and JUMP over PC_INC
    step(16'h0, 1'b1, m_mar, 8'h0F);
    step(RAM_OUT | JUMP);
    peek(PC_OUT, "pc_15", 15);
    step(PC_INC);
    peek(PC_OUT, "pc_wrap", 0);
    step(16'h0, 1'b1, m_mar, 8'h89);
    step(RAM_OUT | IR_IN);
    step(IR_OUT | JUMP | PC_INC);
    peek(PC_OUT, "pc_jump", 9);
    check("jump_opcode", ir_data, 8);

    // Bus conflict: sticky
    check("conf_clear", conflict, 0);
    step(16'h0, 1'b1, m_mar, 8'h55);
    step(RAM_OUT | A_IN);
    peek(A_OUT | PC_OUT, "conf_bus", 8'h55);
    step(A_OUT | PC_OUT);
    check("conf_set", conflict, 1);
    for (int i = 0; i < 10; i++) step(16'h0);
    check("conf_sticky", conflict, 1);

    // Randomized control words (no HALT), occasional loader writes
    for (int i = 0; i < 400; i++) begin
      logic [15:0] c;
      c = 16'($urandom) & 16'h7FFF;
      if ($urandom_range(0, 3) == 0)
        step(c, 1'b1, int'($urandom_range(0, 15)), int'($urandom_range(0, 255)));
      else
        step(c);
    end

    // Halt: later loads suppressed, loader still works
    step(16'h0, 1'b1, m_mar, 8'hC3);
    step(RAM_OUT | A_IN);
    a_keep = m_a;
    step(16'h0, 1'b1, m_mar, 8'h33);
    step(HALT);
    check("halted", halted, 1);
    peek(RAM_OUT, "halt_bus", 8'h33);
    step(RAM_OUT | A_IN);
    peek(A_OUT, "halt_a_kept", a_keep);
    check("halt_a_is_c3", a_keep, 8'hC3);
    step(PC_INC | RAM_IN | IR_IN | OUT_IN | FLAGS | JUMP);
    check("halt_still", halted, 1);
    step(16'h0, 1'b1, 0, 8'h77);

    // Asynchronous reset mid-cycle
    ctrl = 16'h0;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_regs("amid");
    peek(A_OUT, "amid_a", 0);
    peek(PC_OUT, "amid_pc", 0);
    @(posedge clk);
    #1;
    peek(RAM_OUT, "ram_kept", 8'h77);
    peek(IR_OUT, "amid_ir", 0);
    rst_n = 1'b1;
    step(PC_INC);
    peek(PC_OUT, "post_rst_pc", 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sap_datapath.md
# sap_datapath

Register/bus datapath that executes the control word produced by the sequencing control unit. Each cycle it performs one bus transfer:
- selects a single bus source;
- latches the bus into every enabled destination register;
- updates flags and PC.

It returns the instruction opcode and the zero/carry flags to the control unit. It owns the A, B, IR, MAR, PC and OUT registers, the flags, the adder/subtractor, and the 16×8 program RAM, which has a loader port.

## Interface
Parameters:
- DATA_WIDTH, 8, bus and register width
- ADDR_WIDTH, 4, PC/MAR width; RAM depth is 2^ADDR_WIDTH
- CONTROL_WIDTH, 16, control word width

Ports:
- i_CLOCK  in  1  single clock; all state updates on the rising edge
- i_RESET_n  in  1  reset, asynchronous and active-low
- i_CONTROL_SIGNALS  in  CONTROL_WIDTH  control word; bit meaning is defined in the shared constants
- i_PROG_WE  in  1  loader write strobe
- i_PROG_ADDR  in  ADDR_WIDTH  loader address
- i_PROG_DATA  in  DATA_WIDTH  loader data
- o_IR_DATA  out  DATA_WIDTH/2  IR[7:4], the opcode
- o_ZERO_FLAG  out  1  registered zero flag
- o_CARRY_FLAG  out  1  registered carry flag
- o_OUT_DATA  out  DATA_WIDTH  OUT register
- o_BUS  out  DATA_WIDTH  current bus value (debug)
- o_HALTED  out  1  sticky halt
- o_BUS_CONFLICT  out  1  sticky: more than one bus source was enabled

## Operation
- **Bus sources:**
  - PC_OUT drives {0, PC}.
  - RAM_OUT drives RAM[MAR].
  - IR_OUT drives {0, IR[3:0]}.
  - A_OUT drives A.
  - ALU_OUT drives the ALU result.
  - With no source enabled, the bus is 0x00.
- **Multiple sources:** priority is ALU_OUT > A_OUT > RAM_OUT > IR_OUT > PC_OUT. o_BUS_CONFLICT sets and stays set until reset.
- **Destinations:** MAR_IN loads bus[3:0]. IR_IN, A_IN, B_IN and OUT_IN each load the full bus. RAM_IN writes the bus to RAM[MAR]. Any number of destinations may load in the same cycle.
- **ALU:** combinational 9-bit result.
  - Add: {1'b0,A} + {1'b0,B}.
  - Subtract (ALU_SUB=1): {1'b0,A} + {1'b0,~B} + 1.
  - Result = sum[7:0]. Carry = sum[8]; for subtract this means "no borrow", i.e. A ≥ B unsigned.
- **Flags:** on FLAGS_UPDATE, zero <= (result == 0) and carry <= sum[8]. Both are computed from pre-edge A and B, even if A_IN loads in the same cycle.
- **PC:**
  - JUMP loads bus[3:0].
  - Otherwise PC_INC increments modulo 16 (15 → 0).
  - JUMP has priority over PC_INC.
- **HALT:** sets o_HALTED. From the following edge onward, all register, flag and RAM updates from the control word are suppressed. The bus stays combinational. Only reset clears o_HALTED.
- **Loader:** i_PROG_WE writes i_PROG_DATA to RAM[i_PROG_ADDR] at any time, including during halt. If it collides with RAM_IN at the same address, the loader wins.

## Timing
- Control word is combinational from the control unit. All effects land on the rising edge that closes the cycle.
- Register-to-register latency is 1 cycle: destinations see the bus value at the next edge.
- RAM read is asynchronous: RAM_OUT in cycle n returns RAM[MAR] as MAR stood during cycle n. A MAR_IN in cycle n takes effect for reads in cycle n+1.
- o_IR_DATA, the flags and o_OUT_DATA are registered and change only on clock edges.
- Reset (asynchronous, any time, including mid-instruction):
  - A, B, IR, MAR, PC, OUT, zero, carry, o_HALTED and o_BUS_CONFLICT go to 0 immediately.
  - RAM contents are preserved.
  - The first edge after deassertion executes the current control word normally.

## Structure
- Shared constants include with bit positions, bit 15 down to bit 0:
  - bits 15–8: HALT, MAR_IN, RAM_IN, RAM_OUT, IR_OUT, IR_IN, A_IN, A_OUT
  - bits 7–0: ALU_OUT, ALU_SUB, B_IN, OUT_IN, PC_INC, PC_OUT, JUMP, FLAGS_UPDATE
  - The control unit uses the same include.
- One sub-module, sap_ram: 16×8, asynchronous read, one write port with loader-over-datapath priority, no reset.
- ALU, bus mux and registers stay in sap_datapath.

## Test plan
- LDA 5 program: load RAM[5]=0x2A, RAM[0]=0x15 via the loader, then run fetch + LDA control words → IR=0x15, o_IR_DATA=1, A=0x2A, PC=1.
- ADD with carry: A=0xF0, B=0x20, word ALU_OUT|A_IN|FLAGS_UPDATE → A=0x10, carry=1, zero=0.
- SUB equal: A=0x07, B=0x07, word ALU_OUT|ALU_SUB|A_IN|FLAGS_UPDATE → A=0x00, zero=1, carry=1. Then A=0x03, B=0x05 → A=0xFE, carry=0.
- PC wrap and priority: PC=15, PC_INC → 0. Then IR=0x89, IR_OUT|JUMP|PC_INC → PC=9.
- Conflict: A_OUT|PC_OUT with A=0x55 → bus=0x55, o_BUS_CONFLICT=1, still 1 after 10 idle cycles.
- Halt/reset: HALT then A_IN with bus 0x33 → A unchanged, o_HALTED=1. Assert i_RESET_n low mid-cycle → all registers 0 before the next edge, RAM data intact.
